keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Input-side counterpart of the display path: scans a 4x4 matrix keypad, synchronizes and debounces the row lines, and encodes the pressed key into a 4-bit value 0..15.
- Delivers each key as a single transaction on a valid/ack handshake.
- The output code feeds the same 4-bit binary datapath that drives the two-digit 7-segment display.

Parameters:
- SCAN_DIV, 1000: clock cycles each column stays driven before its rows are sampled (min 2).
- DEBOUNCE_CYCLES, 20000: consecutive stable cycles required to accept a press or a release (min 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high.
- row_in  in  4  keypad rows; active-low, pulled up externally, asynchronous to clk.
- col_out  out  4  column drive; active-low one-hot, exactly one column low at all times.
- key_code  out  4  encoded key; stable while key_valid=1.
- key_valid  out  1  a key is pending; held until acknowledged.
- key_ack  in  1  consumer accepts the pending key.
- overrun  out  1  a key was dropped because one was already pending.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high on rst.
- Reset values: col_out=4'b1110 (column 0), key_code=0, key_valid=0, overrun=0, state SCAN, all counters 0, row synchronizer flops=4'b1111.
- Row synchronization: row_in passes through 2 flops to row_s. All decisions use row_s.
- Key map (row r, col c): r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: *,0,#,D.
- Codes: digit n -> n; A=10, B=11, C=12, D=13, *=14, #=15.
- FSM state SCAN:
  - The dwell counter counts 0..SCAN_DIV-1 and produces a tick on SCAN_DIV-1.
  - On tick with row_s==4'b1111: the column index advances (3 wraps to 0), col_out updates next cycle, and the dwell counter restarts.
  - On tick with any row low: latch the lowest-index low row and the current column, clear the debounce counter, and go to DEBOUNCE. The column is frozen.
- FSM state DEBOUNCE:
  - Each cycle the latched row is low, the counter increments.
  - When the latched row reaches DEBOUNCE_CYCLES consecutive low cycles, the key is issued and the FSM goes to HELD.
  - If the latched row goes high first, return to SCAN on the same column with the dwell counter at 0. No key is issued.
- Key issue:
  - If key_valid=0, or key_ack=1 in the same cycle: key_code<=map(row,col) and key_valid<=1 next cycle.
  - Otherwise key_code and key_valid are unchanged and overrun<=1.
- FSM state HELD: wait for the latched row high, then go to RELEASE with the counter cleared. Other rows are ignored, so there is no rollover.
- FSM state RELEASE:
  - Count consecutive high cycles of the latched row. Any low cycle sends the FSM back to HELD.
  - When DEBOUNCE_CYCLES is reached, go to SCAN, advance to the next column, and restart the dwell counter.
- Handshake:
  - key_ack with key_valid=1 clears key_valid and overrun next cycle. key_ack with key_valid=0 is ignored.
  - Ack and issue in the same cycle: the new key wins, key_valid stays 1, and overrun is not set.
- Output timing: key_valid rises exactly one cycle after the DEBOUNCE_CYCLES-th stable low sample. The exactly-one-column-low invariant on col_out holds in every state.
- Reset mid-operation: rst asserted in any state returns everything to its reset value on the next edge. A pending key is discarded.
- Counter widths: $clog2 of each parameter, with no wrap beyond the terminal count.

Decomposition:
- Package keypad_pkg holds:
  - the state enum (SCAN, DEBOUNCE, HELD, RELEASE);
  - the 16-entry key-map constant indexed {row,col};
  - named code constants KEY_A..KEY_HASH.
- One sub-module, keypad_sync: a parameterized-width 2-flop synchronizer with synchronous reset to all-ones, instantiated for row_in.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=8):
- Reset check: hold rst 3 cycles with row_in=4'b1111 -> col_out=4'b1110, key_valid=0, overrun=0. Afterwards col_out cycles 1110->1101->1011->0111->1110, each value held 4 cycles.
- Clean press of "9" (row 2, col 2): while col_out=4'b1011, drive row_in[2]=0 for 40 cycles -> key_valid=1 with key_code=9, 8 cycles after detection; col_out stays 1011 until release plus 8 high cycles, then moves to 0111.
- Bounce rejection: on row 0 / col 3, toggle low 3 cycles, high 2 cycles, repeated 4 times, then release -> key_valid never asserts and scanning resumes on col 3. A subsequent clean hold of 20 cycles gives key_code=10 (A).
- Overrun: press "*" (code 14) with no ack, release, then press "0" -> key_code stays 14, key_valid=1, overrun=1. key_ack for 1 cycle -> key_valid=0 and overrun=0 next cycle.
- Same-cycle ack and issue: pending "5"; assert key_ack exactly on the issue cycle of "D" -> key_valid stays 1, key_code=13, overrun=0.
- Reset mid-operation and multi-row: assert rst during DEBOUNCE -> reset values next cycle and no key issued. Rows 1 and 3 low together on col 0 -> key_code=4 (lowest row wins).

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, key codes
// and the {row,col} -> code map.
package keypad_pkg;

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

   localparam logic [3:0] KEY_A    = 4'd10;
   localparam logic [3:0] KEY_B    = 4'd11;
   localparam logic [3:0] KEY_C    = 4'd12;
   localparam logic [3:0] KEY_D    = 4'd13;
   localparam logic [3:0] KEY_STAR = 4'd14;
   localparam logic [3:0] KEY_HASH = 4'd15;

   // Indexed by {row, col}
   localparam logic [3:0] KEY_MAP [0:15] = '{
      4'd1,     4'd2, 4'd3,     KEY_A,
      4'd4,     4'd5, 4'd6,     KEY_B,
      4'd7,     4'd8, 4'd9,     KEY_C,
      KEY_STAR, 4'd0, KEY_HASH, KEY_D
   };

   // Index of the lowest-numbered active-low row; only meaningful when some row is low.
   function automatic logic [1:0] lowest_low(input logic [3:0] rows);
      logic [1:0] idx;
      idx = 2'd3;
      for (int i = 3; i >= 0; i--) begin
         if (!rows[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for asynchronous active-low lines; resets to all-ones
// so an idle keypad reads as released.
module keypad_sync #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= '1;
         q      <= '1;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, row debounce, key encode and a
// valid/ack handshake with overrun flag.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV        = 1000,
   parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ack,
   output logic       overrun
);

   localparam int unsigned DW = $clog2(SCAN_DIV);
   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);

   logic [3:0]    row_s;
   state_t        state_q;
   logic [1:0]    col_q;
   logic [1:0]    row_q;
   logic [DW-1:0] dwell_q;
   logic [CW-1:0] cnt_q;
   logic [1:0]    col_nxt;

   keypad_sync #(
      .WIDTH (4)
   ) u_row_sync (
      .clk (clk),
      .rst (rst),
      .d   (row_in),
      .q   (row_s)
   );

   assign col_nxt = col_q + 2'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= SCAN;
         col_q     <= 2'd0;
         row_q     <= 2'd0;
         dwell_q   <= '0;
         cnt_q     <= '0;
         col_out   <= 4'b1110;
         key_code  <= 4'd0;
         key_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         // Issue below may override this when both happen in the same cycle.
         if (key_ack && key_valid) begin
            key_valid <= 1'b0;
            overrun   <= 1'b0;
         end

         unique case (state_q)
            SCAN: begin
               if (dwell_q == DWELL_LAST) begin
                  dwell_q <= '0;
                  if (row_s == 4'b1111) begin
                     col_q   <= col_nxt;
                     col_out <= ~(4'b0001 << col_nxt);
                  end else begin
                     row_q   <= lowest_low(row_s);
                     cnt_q   <= '0;
                     state_q <= DEBOUNCE;
                  end
               end else begin
                  dwell_q <= dwell_q + 1'b1;
               end
            end

            DEBOUNCE: begin
               if (!row_s[row_q]) begin
                  if (cnt_q == CNT_LAST) begin
                     state_q <= HELD;
                     if (!key_valid || key_ack) begin
                        key_code  <= KEY_MAP[{row_q, col_q}];
                        key_valid <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end else begin
                  state_q <= SCAN;
                  dwell_q <= '0;
               end
            end

            HELD: begin
               // Only the latched row matters here; other rows are ignored.
               if (row_s[row_q]) begin
                  state_q <= RELEASE;
                  cnt_q   <= '0;
               end
            end

            RELEASE: begin
               if (!row_s[row_q]) begin
                  state_q <= HELD;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= SCAN;
                  dwell_q <= '0;
                  col_q   <= col_nxt;
                  col_out <= ~(4'b0001 << col_nxt);
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
         endcase
      end
   end

endmodule
